instr_fetch: RTL

Instruction fetch stage between the program counter and decode. Consumes the current PC, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions with their PCs in a small queue. Presents instructions to decode over a valid/ready handshake. Drives the PC's advance enable, so the PC only moves when a fetch is accepted. Handles jump redirects by flushing queued and in-flight fetches.

---
 rtl/if_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/instr_fetch.sv | 137 +++++++++++++
 3 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry layout
// and the word-alignment helper.
package if_pkg;

    localparam int IF_XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs until decode takes them.
// The head entry is read straight from the storage registers.
module fetch_fifo
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic                clear,
    input  fetch_entry_t        push_data,
    output fetch_entry_t        head,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
);

    fetch_entry_t    mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: issues one outstanding word read per PC, pairs each response with
// its captured PC, queues it for decode, and discards in-flight work on redirect.
module instr_fetch
    import if_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_in,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            if_ready,
    output logic            fault
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] cap_pc;

    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;

    logic            aligned;
    logic            resp_in_wait;
    logic            room;
    logic            issue_ok;
    logic            misaligned;
    logic            push;
    logic            pop;

    // Pops in the current cycle are deliberately not credited, so room is judged
    // on the registered count; a response landing this cycle needs its own slot.
    assign aligned      = word_aligned(pc_in[1:0]);
    assign resp_in_wait = (state == WAIT) & imem_resp_valid;
    assign room         = ((state == IDLE) & ~full)
                        | (resp_in_wait & ((count + CW'(1)) < CW'(DEPTH)));
    assign issue_ok     = room & ~flush & ~rst;

    assign imem_req_valid = issue_ok & aligned;
    assign misaligned     = issue_ok & ~aligned;
    assign imem_req_addr  = pc_in;
    assign pc_en          = imem_req_valid & imem_req_ready;

    assign push       = resp_in_wait & ~flush;
    assign pop        = if_valid & if_ready & ~flush;
    assign push_entry = '{pc: cap_pc, instr: imem_resp_data};

    assign if_valid = ~empty;
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .clear     (flush),
        .push_data (push_entry),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Flush outranks everything; an outstanding request without its response
    // yet must still be drained, which is what DROP remembers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            fault  <= 1'b0;
            cap_pc <= '0;
        end else begin
            if (pc_en) begin
                cap_pc <= pc_in;
            end
            if (flush) begin
                fault <= 1'b0;
                case (state)
                    WAIT:    state <= imem_resp_valid ? IDLE : DROP;
                    DROP:    state <= imem_resp_valid ? IDLE : DROP;
                    default: state <= IDLE;
                endcase
            end else begin
                case (state)
                    IDLE: begin
                        if (pc_en) begin
                            state <= WAIT;
                        end else if (misaligned) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (imem_resp_valid) begin
                            if (pc_en) begin
                                state <= WAIT;
                            end else if (misaligned) begin
                                state <= FAULT;
                                fault <= 1'b1;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DROP: begin
                        if (imem_resp_valid) begin
                            state <= IDLE;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
